mem_sdp_pipe: RTL

//  Parametrised simple-dual-port RAM: one write port, RD_PORTS independent read channels.

---
 rtl/mem_sdp_pkg.sv | 20 ++
 rtl/mem_sdp_rd_pipe.sv | 49 ++++
 rtl/mem_sdp_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_sdp_pkg.sv
// Shared types and helpers for the simple-dual-port scratch memory (mem_sdp_pipe).
// Parity helper is used only when MEM_SDP_PARITY_EN is defined.
package mem_sdp_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sdp_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int PAR_MAX_W = 64;

  function automatic logic parity_even(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mem_sdp_rd_pipe.sv
// One read channel's RD_LAT-deep delay line of {valid, err, payload}; payload only
// advances with a valid beat so the last stage holds the most recent returned word.
module mem_sdp_rd_pipe #(
  parameter int PAY_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_err,
  input  logic [PAY_W-1:0] in_pay,
  output logic             out_valid,
  output logic             out_err,
  output logic [PAY_W-1:0] out_pay
);

  logic [RD_LAT-1:0] valid_r;
  logic [RD_LAT-1:0] err_r;
  logic [PAY_W-1:0]  pay_r [RD_LAT];

  // Delay line: flags shift every cycle, payload moves only alongside a valid beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= '0;
      err_r   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pay_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      err_r[0]   <= in_valid & in_err;
      if (in_valid) begin
        pay_r[0] <= in_pay;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        err_r[i]   <= err_r[i-1];
        if (valid_r[i-1]) begin
          pay_r[i] <= pay_r[i-1];
        end
      end
    end
  end

  assign out_valid = valid_r[RD_LAT-1];
  assign out_err   = err_r[RD_LAT-1];
  assign out_pay   = pay_r[RD_LAT-1];

endmodule

// File: rtl/mem_sdp_pipe.sv
// Simple-dual-port RAM: one write port, RD_PORTS pipelined read channels, zero-fill after reset.
// Optional MEM_SDP_PARITY_EN adds a stored even-parity bit per word and a perr output.
module mem_sdp_pipe
  import mem_sdp_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MEM_SIZE  = 6,
  parameter int ADDR_SIZE = $clog2(MEM_SIZE),
  parameter int RD_PORTS  = 2,
  parameter int RD_LAT    = 1,
  parameter int RDW_MODE  = 0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  output logic                          init_busy,
  input  logic                          write,
  input  logic [ADDR_SIZE-1:0]          addr_w,
  input  logic [DATA_W-1:0]             datain,
  output logic                          werr,
  input  logic [RD_PORTS-1:0]           read,
  input  logic [RD_PORTS*ADDR_SIZE-1:0] addr_r,
  output logic [RD_PORTS*DATA_W-1:0]    dataout,
  output logic [RD_PORTS-1:0]           rvalid,
  output logic [RD_PORTS-1:0]           rerr
`ifdef MEM_SDP_PARITY_EN
  ,
  output logic [RD_PORTS-1:0]           perr
`endif
);

`ifdef MEM_SDP_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  // One extra bit so a power-of-two MEM_SIZE still compares without wrapping.
  localparam logic [ADDR_SIZE:0]   MEM_LIMIT = MEM_SIZE[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_SIZE - 1);

  sdp_state_e           state_r;
  sdp_state_e           next_state_s;
  logic [ADDR_SIZE-1:0] fill_ptr_r;
  logic [ADDR_SIZE-1:0] next_ptr_s;
  logic                 init_busy_r;
  logic                 werr_r;
  logic                 next_werr_s;

  logic [WORD_W-1:0]    mem_r [MEM_SIZE];

  logic                 ready_s;
  logic                 fill_en_s;
  logic                 wr_oob_s;
  logic                 wr_ok_s;
  logic [WORD_W-1:0]    wr_word_s;

  assign ready_s   = (state_r == ST_READY);
  assign fill_en_s = (state_r == ST_INIT);
  assign wr_oob_s  = ({1'b0, addr_w} >= MEM_LIMIT);
  assign wr_ok_s   = write & ready_s & ~wr_oob_s;

`ifdef MEM_SDP_PARITY_EN
  assign wr_word_s = {parity_even(PAR_MAX_W'(datain)), datain};
`else
  assign wr_word_s = datain;
`endif

  // Sequencer next state: walk the fill pointer once, then stay READY until reset.
  always_comb begin
    next_state_s = state_r;
    next_ptr_s   = fill_ptr_r;
    case (state_r)
      ST_INIT: begin
        if (fill_ptr_r == LAST_ADDR) begin
          next_state_s = ST_READY;
        end else begin
          next_ptr_s = fill_ptr_r + ADDR_SIZE'(1'b1);
        end
      end
      ST_READY: begin
        next_state_s = ST_READY;
      end
      default: begin
        next_state_s = ST_INIT;
        next_ptr_s   = '0;
      end
    endcase
    next_werr_s = write & (fill_en_s | wr_oob_s);
  end

  // Sequencer and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_INIT;
      fill_ptr_r  <= '0;
      init_busy_r <= 1'b1;
      werr_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      fill_ptr_r  <= next_ptr_s;
      init_busy_r <= (next_state_s == ST_INIT);
      werr_r      <= next_werr_s;
    end
  end

  // Storage: zero-fill while initialising, accepted user writes afterwards.
  always_ff @(posedge clock) begin
    if (fill_en_s) begin
      mem_r[fill_ptr_r] <= '0;
    end else if (wr_ok_s) begin
      mem_r[addr_w] <= wr_word_s;
    end
  end

  assign init_busy = init_busy_r;
  assign werr      = werr_r;

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_SIZE-1:0] addr_s;
    logic                 oob_s;
    logic                 hit_s;
    logic [WORD_W-1:0]    word_s;
    logic [WORD_W-1:0]    pay_s;
    logic [WORD_W-1:0]    out_pay_s;

    assign addr_s = addr_r[k*ADDR_SIZE +: ADDR_SIZE];
    assign oob_s  = ({1'b0, addr_s} >= MEM_LIMIT);
    // Forward the incoming word only when configured for new-data and the addresses match.
    assign hit_s  = (RDW_MODE == RDW_NEW) && wr_ok_s && (addr_w == addr_s);
    assign word_s = hit_s ? wr_word_s : mem_r[addr_s];

`ifdef MEM_SDP_PARITY_EN
    assign pay_s = oob_s ? '0
                 : {word_s[DATA_W] ^ parity_even(PAR_MAX_W'(word_s[DATA_W-1:0])),
                    word_s[DATA_W-1:0]};
    assign perr[k] = out_pay_s[DATA_W];
`else
    assign pay_s = oob_s ? '0 : word_s;
`endif

    mem_sdp_rd_pipe #(
      .PAY_W  (WORD_W),
      .RD_LAT (RD_LAT)
    ) u_rd_pipe (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (read[k] & ready_s),
      .in_err    (oob_s),
      .in_pay    (pay_s),
      .out_valid (rvalid[k]),
      .out_err   (rerr[k]),
      .out_pay   (out_pay_s)
    );

    assign dataout[k*DATA_W +: DATA_W] = out_pay_s[DATA_W-1:0];
  end

endmodule
